qupls4_imul_sched: RTL and testbench

Issue scheduler and writeback buffer for the shared pipelined integer multiplier in the Qupls4 execute stage. It arbitrates up to NREQ reservation-station requesters round-robin and issues at most one multiply per cycle into the fixed-latency, non-stallable multiplier. It tracks each in-flight tag through a valid/tag shadow pipeline. Results are captured into a small writeback FIFO, with credit-based issue throttling so no result is ever lost when writeback stalls.

---
 rtl/qupls4_pkg.sv | 6 +
 rtl/qupls4_imul_wbfifo.sv | 67 ++++++
 rtl/qupls4_imul_sched.sv | 130 +++++++++++++
 tb/tb_qupls4_imul_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/qupls4_pkg.sv
// Shared Qupls4 execute-stage items: ROB tag type and the integer multiplier latency.
package qupls4_pkg;
   localparam int IMUL_LAT = 4;
   localparam int ROB_TAGW = 8;
   typedef logic [ROB_TAGW-1:0] rob_tag_t;
endpackage

// File: rtl/qupls4_imul_wbfifo.sv
// Writeback buffer for multiplier results: first-word-fall-through {tag, result} FIFO
// with a synchronous clear used by pipeline flush.
module qupls4_imul_wbfifo
   import qupls4_pkg::*;
#(
   parameter int TAGW  = ROB_TAGW,
   parameter int WID   = 64,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            wr,
   input  logic [TAGW-1:0] wr_tag,
   input  logic [WID-1:0]  wr_res,
   input  logic            rd,
   output logic [TAGW-1:0] rd_tag,
   output logic [WID-1:0]  rd_res,
   output logic            full,
   output logic            empty
);

   logic [TAGW-1:0] tag_mem [DEPTH];
   logic [WID-1:0]  res_mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   cnt;
   logic            wr_en, rd_en;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign wr_en = wr && !full && !clr;
   assign rd_en = rd && !empty && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (clr) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_en) wptr <= inc(wptr);
         if (rd_en) rptr <= inc(rptr);
         cnt <= cnt + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Storage is not reset; the head is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wptr] <= wr_tag;
         res_mem[wptr] <= wr_res;
      end
   end

   assign rd_tag = empty ? '0 : tag_mem[rptr];
   assign rd_res = empty ? '0 : res_mem[rptr];

endmodule

// File: rtl/qupls4_imul_sched.sv
// Issue scheduler for the shared pipelined integer multiplier: round-robin grant,
// credit throttling against the writeback FIFO, and a valid/tag shadow pipeline.
module qupls4_imul_sched
   import qupls4_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int TAGW  = ROB_TAGW,
   parameter int WID   = 64,
   parameter int LAT   = IMUL_LAT,
   parameter int DEPTH = 4,
   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ-1:0][TAGW-1:0] req_tag_i,
   output logic [NREQ-1:0]           gnt_o,
   output logic                      mul_issue_o,
   output logic [SW-1:0]             mul_sel_o,
   input  logic [WID-1:0]            mul_res_i,
   input  logic                      flush_i,
   output logic                      wb_valid_o,
   output logic [TAGW-1:0]           wb_tag_o,
   output logic [WID-1:0]            wb_res_o,
   input  logic                      wb_ready_i,
   output logic                      busy_o
);

   logic [SW-1:0]   ptr;
   logic [OW-1:0]   occ;
   logic            grant_en, pop;
   logic [TAGW-1:0] issue_tag;
   logic            wr_vld, fifo_wr, fifo_full, fifo_empty;
   logic [TAGW-1:0] wr_tag;

   // A pop in the same cycle does not free a credit for this cycle's grant.
   assign grant_en = !rst && !flush_i && (occ < OW'(DEPTH));

   // Scan from the farthest lane down so the nearest lane after ptr wins.
   always_comb begin
      gnt_o     = '0;
      mul_sel_o = '0;
      if (grant_en) begin
         for (int i = NREQ; i >= 1; i--) begin
            automatic int lane = (int'(ptr) + i) % NREQ;
            if (req_i[lane]) begin
               gnt_o       = '0;
               gnt_o[lane] = 1'b1;
               mul_sel_o   = SW'(lane);
            end
         end
      end
   end

   assign mul_issue_o = |gnt_o;
   assign issue_tag   = req_tag_i[mul_sel_o];
   assign pop         = wb_valid_o && wb_ready_i && !flush_i;
   assign busy_o      = (occ != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= SW'(NREQ - 1);
         occ <= '0;
      end else begin
         if (mul_issue_o) ptr <= mul_sel_o;
         if (flush_i)
            occ <= '0;
         else if (mul_issue_o && !pop)
            occ <= occ + 1'b1;
         else if (!mul_issue_o && pop)
            occ <= occ - 1'b1;
      end
   end

   // Stage 0 is the issue cycle itself; stage LAT-1 coincides with the result on mul_res_i.
   generate
      if (LAT == 1) begin : g_nopipe
         assign wr_vld = mul_issue_o;
         assign wr_tag = issue_tag;
      end else begin : g_pipe
         logic [LAT-1:1]           vld_pipe;
         logic [LAT-1:1][TAGW-1:0] tag_pipe;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_pipe <= '0;
               tag_pipe <= '0;
            end else begin
               vld_pipe[1] <= mul_issue_o && !flush_i;
               tag_pipe[1] <= issue_tag;
               for (int k = 2; k < LAT; k++) begin
                  vld_pipe[k] <= vld_pipe[k-1] && !flush_i;
                  tag_pipe[k] <= tag_pipe[k-1];
               end
            end
         end

         assign wr_vld = vld_pipe[LAT-1];
         assign wr_tag = tag_pipe[LAT-1];
      end
   endgenerate

   assign fifo_wr    = wr_vld && !flush_i;
   assign wb_valid_o = !fifo_empty;

   qupls4_imul_wbfifo #(
      .TAGW  (TAGW),
      .WID   (WID),
      .DEPTH (DEPTH)
   ) u_wbfifo (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush_i),
      .wr     (fifo_wr),
      .wr_tag (wr_tag),
      .wr_res (mul_res_i),
      .rd     (pop),
      .rd_tag (wb_tag_o),
      .rd_res (wb_res_o),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Credits bound in-flight plus buffered ops to DEPTH, so a write never meets a full FIFO.
   always @(posedge clk) begin
      if (!rst && fifo_wr) assert (!fifo_full);
   end

endmodule

// File: tb/tb_qupls4_imul_sched.sv
// Self-checking bench for qupls4_imul_sched: directed scenarios plus a random phase,
// compared each cycle against a queue-based model of in-flight ops and the writeback buffer.
module tb_qupls4_imul_sched;
   localparam int NREQ = 4, TAGW = 8, WID = 64, LAT = 4, DEPTH = 4;

   logic                      clk, rst;
   logic [NREQ-1:0]           req_i;
   logic [NREQ-1:0][TAGW-1:0] req_tag_i;
   logic [NREQ-1:0]           gnt_o;
   logic                      mul_issue_o;
   logic [1:0]                mul_sel_o;
   logic [WID-1:0]            mul_res_i;
   logic                      flush_i;
   logic                      wb_valid_o;
   logic [TAGW-1:0]           wb_tag_o;
   logic [WID-1:0]            wb_res_o;
   logic                      wb_ready_i;
   logic                      busy_o;

   qupls4_imul_sched #(.NREQ(NREQ), .TAGW(TAGW), .WID(WID), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .req_tag_i(req_tag_i), .gnt_o(gnt_o),
      .mul_issue_o(mul_issue_o), .mul_sel_o(mul_sel_o), .mul_res_i(mul_res_i),
      .flush_i(flush_i), .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o),
      .wb_res_o(wb_res_o), .wb_ready_i(wb_ready_i), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TAGW-1:0] tag;
      logic [WID-1:0]  res;
      int              cyc;
   } op_t;

   op_t        inflight[$];
   op_t        fifo_q[$];
   int         issued_lane[$];
   int         ptr_m, cnum, checks, failures;
   bit         hold, ovr_en;
   logic [WID-1:0] res_ovr;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One clock cycle: drive the model multiplier, check outputs, advance the model.
   task automatic cyc();
      op_t o;
      int lane, occ_m;
      logic [NREQ-1:0] g;
      if (inflight.size() > 0 && inflight[0].cyc == cnum - (LAT - 1))
         mul_res_i = inflight[0].res;
      else
         mul_res_i = {$urandom, $urandom};
      #1;
      occ_m = inflight.size() + fifo_q.size();
      lane = -1;
      g = '0;
      if (!flush_i && occ_m < DEPTH)
         for (int i = 1; i <= NREQ; i++) begin
            automatic int l = (ptr_m + i) % NREQ;
            if (lane < 0 && req_i[l]) lane = l;
         end
      if (lane >= 0) g[lane] = 1'b1;
      chk("gnt", gnt_o, g);
      chk("issue", mul_issue_o, lane >= 0);
      if (lane >= 0) chk("sel", mul_sel_o, lane);
      chk("wb_valid", wb_valid_o, fifo_q.size() > 0);
      chk("wb_tag", wb_tag_o, (fifo_q.size() > 0) ? fifo_q[0].tag : '0);
      chk("wb_res", wb_res_o, (fifo_q.size() > 0) ? fifo_q[0].res : '0);
      chk("busy", busy_o, occ_m != 0);
      if (flush_i) begin
         inflight.delete();
         fifo_q.delete();
      end else begin
         if (fifo_q.size() > 0 && wb_ready_i) void'(fifo_q.pop_front());
         if (inflight.size() > 0 && inflight[0].cyc == cnum - (LAT - 1))
            fifo_q.push_back(inflight.pop_front());
         if (lane >= 0) begin
            o.tag = req_tag_i[lane];
            o.res = ovr_en ? res_ovr : {$urandom, $urandom};
            o.cyc = cnum;
            ovr_en = 1'b0;
            inflight.push_back(o);
            ptr_m = lane;
            issued_lane.push_back(lane);
         end
      end
      cnum++;
      @(posedge clk);
      #1;
      if (lane >= 0) begin
         if (hold) req_tag_i[lane] = TAGW'($urandom);
         else      req_i[lane] = 1'b0;
      end
   endtask

   initial begin
      checks = 0; failures = 0; cnum = 0; ptr_m = NREQ - 1;
      hold = 0; ovr_en = 0; res_ovr = '0;
      rst = 1'b1; req_i = '1; flush_i = 0; wb_ready_i = 0; mul_res_i = '0;
      for (int l = 0; l < NREQ; l++) req_tag_i[l] = TAGW'(l);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_issue", mul_issue_o, 0);
      chk("rst_wbv", wb_valid_o, 0);
      chk("rst_tag", wb_tag_o, 0);
      chk("rst_res", wb_res_o, 0);
      chk("rst_busy", busy_o, 0);
      req_i = '0;
      rst = 1'b0;

      // Single op on lane 2
      req_i = 4'b0100; req_tag_i[2] = 8'h15; res_ovr = 64'h1234; ovr_en = 1;
      #1 chk("single_gnt", gnt_o, 4'b0100);
      cyc();
      repeat (3) cyc();
      chk("single_wbv", wb_valid_o, 1);
      chk("single_tag", wb_tag_o, 8'h15);
      chk("single_res", wb_res_o, 64'h1234);
      wb_ready_i = 1;
      cyc();

      // Round-robin, all lanes continuously
      hold = 1; req_i = '1; issued_lane.delete();
      repeat (20) cyc();
      for (int i = 1; i < issued_lane.size(); i++)
         chk("rr_order", issued_lane[i], (issued_lane[i-1] + 1) % NREQ);
      hold = 0; req_i = '0;
      repeat (8) cyc();

      // Backpressure: only DEPTH issues, then one pop buys exactly one more
      wb_ready_i = 0; hold = 1; req_i = 4'b0001; issued_lane.delete();
      repeat (10) cyc();
      chk("bp_issues", issued_lane.size(), DEPTH);
      chk("bp_gnt", gnt_o, 0);
      chk("bp_busy", busy_o, 1);
      wb_ready_i = 1;
      cyc();
      wb_ready_i = 0; issued_lane.delete();
      cyc();
      chk("bp_reissue", issued_lane.size(), 1);
      repeat (3) cyc();
      chk("bp_one_only", issued_lane.size(), 1);
      hold = 0; req_i = '0; wb_ready_i = 1;
      repeat (10) cyc();

      // Issue and pop together at occ=3: no credit gained, no overflow
      wb_ready_i = 0; hold = 1; req_i = 4'b0001;
      repeat (3) cyc();
      req_i = '0;
      repeat (5) cyc();
      wb_ready_i = 1; req_i = 4'b0001; issued_lane.delete();
      cyc();
      wb_ready_i = 0;
      repeat (4) cyc();
      chk("simul_issues", issued_lane.size(), 2);
      hold = 0; req_i = '0; wb_ready_i = 1;
      repeat (10) cyc();

      // Flush kills in-flight and buffered ops
      req_i = 4'b0111; req_tag_i[0] = 8'h31; req_tag_i[1] = 8'h32; req_tag_i[2] = 8'h33;
      repeat (3) cyc();
      cyc();
      flush_i = 1;
      cyc();
      flush_i = 0;
      chk("flush_busy", busy_o, 0);
      repeat (5) begin
         chk("flush_nowb", wb_valid_o, 0);
         cyc();
      end
      req_i = 4'b0010; req_tag_i[1] = 8'hA5;
      cyc();
      repeat (3) cyc();
      chk("flush_wbv", wb_valid_o, 1);
      chk("flush_tag", wb_tag_o, 8'hA5);
      repeat (3) cyc();

      // Asynchronous reset with ops in flight and buffered
      wb_ready_i = 0; req_i = 4'b0111;
      repeat (5) cyc();
      chk("pre_arst_wbv", wb_valid_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_wbv", wb_valid_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_gnt", gnt_o, 0);
      #1 rst = 1'b0;
      inflight.delete(); fifo_q.delete(); ptr_m = NREQ - 1;
      req_i = '1;
      #1 chk("arst_first", gnt_o, 4'b0001);
      wb_ready_i = 1;
      cyc();
      req_i = '0;
      repeat (8) cyc();

      // Random traffic
      hold = 0;
      repeat (400) begin
         for (int l = 0; l < NREQ; l++)
            if (!req_i[l] && $urandom_range(0, 2) == 0) begin
               req_i[l] = 1'b1;
               req_tag_i[l] = TAGW'($urandom);
            end
         flush_i = ($urandom_range(0, 39) == 0);
         wb_ready_i = ($urandom_range(0, 3) != 0);
         cyc();
      end
      flush_i = 0; req_i = '0; wb_ready_i = 1;
      repeat (10) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
